// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the CPU memory-port arbiter: FSM states, port/op encodings, latency default.
// Also used by the CPU and by the bench-side memory model.
package mem_port_arbiter_pkg;

   localparam int unsigned MemLatencyDefault = 2;

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StResp
   } arb_state_e;

   typedef enum logic {
      OwnerI,
      OwnerD
   } owner_e;

   typedef enum logic {
      OpRd,
      OpWr
   } op_e;

   // Counter width able to hold values 0..latency.
   function automatic int unsigned cnt_width(input int unsigned latency);
      return (latency < 1) ? 1 : $clog2(latency + 1);
   endfunction

endpackage

// File: rtl/arb_latency_counter.sv
// Down-counter timing one memory access: loaded at grant, decremented each access cycle,
// zero flag marks the final access cycle.
module arb_latency_counter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned MEM_LATENCY = MemLatencyDefault
) (
   input  logic Clk,
   input  logic Reset_N,
   input  logic load_i,
   input  logic dec_i,
   output logic zero_o
);

   localparam int unsigned CntW = cnt_width(MEM_LATENCY);
   localparam logic [CntW-1:0] LoadVal = CntW'(MEM_LATENCY - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LoadVal;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_N) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between the CPU fetch and data ports.
// Data wins contention unless it won the previous grant; every output is registered.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned WORD_SIZE   = 16,
   parameter int unsigned MEM_LATENCY = MemLatencyDefault
) (
   input  logic                 Clk,
   input  logic                 Reset_N,
   input  logic                 i_req,
   input  logic [WORD_SIZE-1:0] i_addr,
   output logic [WORD_SIZE-1:0] i_rdata,
   output logic                 i_ready,
   input  logic                 d_req_read,
   input  logic                 d_req_write,
   input  logic [WORD_SIZE-1:0] d_addr,
   input  logic [WORD_SIZE-1:0] d_wdata,
   output logic [WORD_SIZE-1:0] d_rdata,
   output logic                 d_ready,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic [WORD_SIZE-1:0] mem_addr,
   output logic [WORD_SIZE-1:0] mem_wdata,
   input  logic [WORD_SIZE-1:0] mem_rdata
);

   arb_state_e           state_q, state_d;
   owner_e               owner_q, owner_d;
   owner_e               last_grant_q, last_grant_d;
   op_e                  op_q, op_d;
   logic [WORD_SIZE-1:0] addr_q, addr_d;
   logic [WORD_SIZE-1:0] wdata_q, wdata_d;
   logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
   logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
   logic                 i_ready_q, i_ready_d;
   logic                 d_ready_q, d_ready_d;
   logic                 mem_read_q, mem_read_d;
   logic                 mem_write_q, mem_write_d;

   logic d_req;
   logic pick_d;
   logic cnt_load;
   logic cnt_dec;
   logic cnt_zero;

   assign d_req  = d_req_read | d_req_write;
   // On contention, data loses only if it took the previous grant.
   assign pick_d = d_req && (!i_req || (last_grant_q != OwnerD));

   arb_latency_counter #(
      .MEM_LATENCY (MEM_LATENCY)
   ) u_lat_cnt (
      .Clk     (Clk),
      .Reset_N (Reset_N),
      .load_i  (cnt_load),
      .dec_i   (cnt_dec),
      .zero_o  (cnt_zero)
   );

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      op_d         = op_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      i_ready_d    = 1'b0;
      d_ready_d    = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (i_req || d_req) begin
               state_d  = StAccess;
               cnt_load = 1'b1;
               if (pick_d) begin
                  owner_d = OwnerD;
                  op_d    = d_req_write ? OpWr : OpRd;
                  addr_d  = d_addr;
                  wdata_d = d_wdata;
               end else begin
                  owner_d = OwnerI;
                  op_d    = OpRd;
                  addr_d  = i_addr;
               end
               last_grant_d = owner_d;
               mem_read_d   = (op_d == OpRd);
               mem_write_d  = (op_d == OpWr);
            end
         end

         StAccess: begin
            if (cnt_zero) begin
               state_d = StResp;
               if (owner_q == OwnerI) begin
                  i_ready_d = 1'b1;
                  i_rdata_d = mem_rdata;
               end else begin
                  d_ready_d = 1'b1;
                  if (op_q == OpRd) begin
                     d_rdata_d = mem_rdata;
                  end
               end
            end else begin
               cnt_dec     = 1'b1;
               mem_read_d  = (op_q == OpRd);
               mem_write_d = (op_q == OpWr);
            end
         end

         // Requests are deliberately not sampled here; the requester gets one edge to drop.
         StResp: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset_N) begin
         state_q      <= StIdle;
         owner_q      <= OwnerI;
         last_grant_q <= OwnerI;
         op_q         <= OpRd;
         addr_q       <= '0;
         wdata_q      <= '0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
         i_ready_q    <= 1'b0;
         d_ready_q    <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
         i_ready_q    <= i_ready_d;
         d_ready_q    <= d_ready_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
      end
   end

   assign i_rdata   = i_rdata_q;
   assign i_ready   = i_ready_q;
   assign d_rdata   = d_rdata_q;
   assign d_ready   = d_ready_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand-written reset and
// contention sequences, against a small word-addressed memory model.
module tb_mem_port_arbiter;

   logic        Clk;
   logic        Reset_N;
   logic        i_req;
   logic [15:0] i_addr;
   logic [15:0] i_rdata;
   logic        i_ready;
   logic        d_req_read;
   logic        d_req_write;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic [15:0] d_rdata;
   logic        d_ready;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   int n_chk  = 0;
   int n_pass = 0;

   mem_port_arbiter dut (
      .Clk         (Clk),
      .Reset_N     (Reset_N),
      .i_req       (i_req),
      .i_addr      (i_addr),
      .i_rdata     (i_rdata),
      .i_ready     (i_ready),
      .d_req_read  (d_req_read),
      .d_req_write (d_req_write),
      .d_addr      (d_addr),
      .d_wdata     (d_wdata),
      .d_rdata     (d_rdata),
      .d_ready     (d_ready),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Memory model: fixed preset contents, overwritten by observed writes.
   bit [15:0]  mem [256];
   bit [255:0] wr_mask;

   function automatic logic [15:0] preset(input logic [7:0] a);
      case (a)
         8'h23:   return 16'h6000;
         8'h30:   return 16'h0A0A;
         8'h40:   return 16'h1234;
         8'h44:   return 16'h5555;
         default: return {a, ~a};
      endcase
   endfunction

   always @(posedge Clk) begin
      if (mem_write) begin
         mem[mem_addr[7:0]]     <= mem_wdata;
         wr_mask[mem_addr[7:0]] <= 1'b1;
      end
   end

   always @(negedge Clk) begin
      mem_rdata = wr_mask[mem_addr[7:0]] ? mem[mem_addr[7:0]] : preset(mem_addr[7:0]);
   end

   typedef struct {
      logic        rst_n;
      logic        i_req;
      logic [15:0] i_addr;
      logic        d_rd;
      logic        d_wr;
      logic [15:0] d_addr;
      logic [15:0] d_wdata;
      logic        mr;
      logic        mw;
      logic [15:0] ma;
      logic [15:0] mwd;
      logic        ir;
      logic [15:0] ird;
      logic        dr;
      logic [15:0] drd;
   } vec_t;

   vec_t vecs[$];

   task automatic v(input logic rst, input logic ir_q, input logic [15:0] ia, input logic drq,
                    input logic dwq, input logic [15:0] da, input logic [15:0] dw,
                    input logic emr, input logic emw, input logic [15:0] ema,
                    input logic [15:0] emwd, input logic eir, input logic [15:0] eird,
                    input logic edr, input logic [15:0] edrd);
      vec_t t;
      t.rst_n = rst;  t.i_req = ir_q; t.i_addr = ia;  t.d_rd = drq;  t.d_wr = dwq;
      t.d_addr = da;  t.d_wdata = dw; t.mr = emr;     t.mw = emw;    t.ma = ema;
      t.mwd = emwd;   t.ir = eir;     t.ird = eird;   t.dr = edr;    t.drd = edrd;
      vecs.push_back(t);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   task automatic drive_idle();
      i_req = 1'b0; i_addr = '0; d_req_read = 1'b0; d_req_write = 1'b0;
      d_addr = '0;  d_wdata = '0;
   endtask

   initial begin
      int n;
      int pulses;
      Reset_N = 1'b0;
      drive_idle();

      // Reset state
      repeat (2) @(posedge Clk);
      #1;
      chk("rst.mem_read", mem_read, 0);
      chk("rst.mem_write", mem_write, 0);
      chk("rst.mem_addr", mem_addr, 0);
      chk("rst.mem_wdata", mem_wdata, 0);
      chk("rst.i_ready", i_ready, 0);
      chk("rst.d_ready", d_ready, 0);
      chk("rst.i_rdata", i_rdata, 0);
      chk("rst.d_rdata", d_rdata, 0);

      // rst ireq iaddr drd dwr daddr dwdata | mr mw maddr mwdata ir irdata dr drdata
      // Fetch alone at 0x0023
      v(1, 1, 'h23, 0, 0, 0, 0,        1, 0, 'h23, 0,   0, 0,       0, 0);
      v(1, 1, 'h23, 0, 0, 0, 0,        1, 0, 'h23, 0,   0, 0,       0, 0);
      v(1, 1, 'h23, 0, 0, 0, 0,        0, 0, 0, 0,      1, 'h6000,  0, 0);
      v(1, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0,      0, 'h6000,  0, 0);
      v(1, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0,      0, 'h6000,  0, 0);
      // Reset, then I and D together: D first, I at the next IDLE edge
      v(0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0,      0, 0,       0, 0);
      v(1, 1, 'h30, 1, 0, 'h40, 0,     1, 0, 'h40, 0,   0, 0,       0, 0);
      v(1, 1, 'h30, 1, 0, 'h40, 0,     1, 0, 'h40, 0,   0, 0,       0, 0);
      v(1, 1, 'h30, 1, 0, 'h40, 0,     0, 0, 0, 0,      0, 0,       1, 'h1234);
      v(1, 1, 'h30, 0, 0, 0, 0,        0, 0, 0, 0,      0, 0,       0, 'h1234);
      v(1, 1, 'h30, 0, 0, 0, 0,        1, 0, 'h30, 0,   0, 0,       0, 'h1234);
      v(1, 1, 'h30, 0, 0, 0, 0,        1, 0, 'h30, 0,   0, 0,       0, 'h1234);
      v(1, 1, 'h30, 0, 0, 0, 0,        0, 0, 0, 0,      1, 'h0A0A,  0, 'h1234);
      v(1, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0,      0, 'h0A0A,  0, 'h1234);
      // Both held: D, I, D, I with ready pulses 4 cycles apart
      v(1, 1, 'h23, 1, 0, 'h44, 0,     1, 0, 'h44, 0,   0, 'h0A0A,  0, 'h1234);
      v(1, 1, 'h23, 1, 0, 'h44, 0,     1, 0, 'h44, 0,   0, 'h0A0A,  0, 'h1234);
      v(1, 1, 'h23, 1, 0, 'h44, 0,     0, 0, 0, 0,      0, 'h0A0A,  1, 'h5555);
      v(1, 1, 'h23, 1, 0, 'h44, 0,     0, 0, 0, 0,      0, 'h0A0A,  0, 'h5555);
      v(1, 1, 'h23, 1, 0, 'h44, 0,     1, 0, 'h23, 0,   0, 'h0A0A,  0, 'h5555);
      v(1, 1, 'h23, 1, 0, 'h44, 0,     1, 0, 'h23, 0,   0, 'h0A0A,  0, 'h5555);
      v(1, 1, 'h23, 1, 0, 'h44, 0,     0, 0, 0, 0,      1, 'h6000,  0, 'h5555);
      v(1, 1, 'h23, 1, 0, 'h44, 0,     0, 0, 0, 0,      0, 'h6000,  0, 'h5555);
      v(1, 1, 'h23, 1, 0, 'h44, 0,     1, 0, 'h44, 0,   0, 'h6000,  0, 'h5555);
      v(1, 1, 'h23, 1, 0, 'h44, 0,     1, 0, 'h44, 0,   0, 'h6000,  0, 'h5555);
      v(1, 1, 'h23, 1, 0, 'h44, 0,     0, 0, 0, 0,      0, 'h6000,  1, 'h5555);
      v(1, 1, 'h23, 1, 0, 'h44, 0,     0, 0, 0, 0,      0, 'h6000,  0, 'h5555);
      v(1, 1, 'h23, 1, 0, 'h44, 0,     1, 0, 'h23, 0,   0, 'h6000,  0, 'h5555);
      v(1, 1, 'h23, 1, 0, 'h44, 0,     1, 0, 'h23, 0,   0, 'h6000,  0, 'h5555);
      v(1, 1, 'h23, 1, 0, 'h44, 0,     0, 0, 0, 0,      1, 'h6000,  0, 'h5555);
      v(1, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0,      0, 'h6000,  0, 'h5555);
      // Write 0xBEEF to 0x0050, then read it back
      v(1, 0, 0, 0, 1, 'h50, 'hBEEF,   0, 1, 'h50, 'hBEEF, 0, 'h6000, 0, 'h5555);
      v(1, 0, 0, 0, 1, 'h50, 'hBEEF,   0, 1, 'h50, 'hBEEF, 0, 'h6000, 0, 'h5555);
      v(1, 0, 0, 0, 1, 'h50, 'hBEEF,   0, 0, 0, 0,      0, 'h6000,  1, 'h5555);
      v(1, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0,      0, 'h6000,  0, 'h5555);
      v(1, 0, 0, 1, 0, 'h50, 0,        1, 0, 'h50, 0,   0, 'h6000,  0, 'h5555);
      v(1, 0, 0, 1, 0, 'h50, 0,        1, 0, 'h50, 0,   0, 'h6000,  0, 'h5555);
      v(1, 0, 0, 1, 0, 'h50, 0,        0, 0, 0, 0,      0, 'h6000,  1, 'hBEEF);
      v(1, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0,      0, 'h6000,  0, 'hBEEF);
      // Read+write together (write wins), address/data changed mid-access
      v(1, 0, 0, 1, 1, 'h60, 'h1111,   0, 1, 'h60, 'h1111, 0, 'h6000, 0, 'hBEEF);
      v(1, 0, 0, 1, 1, 'h99, 'h2222,   0, 1, 'h60, 'h1111, 0, 'h6000, 0, 'hBEEF);
      v(1, 0, 0, 1, 1, 'h99, 'h2222,   0, 0, 0, 0,      0, 'h6000,  1, 'hBEEF);
      v(1, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0,      0, 'h6000,  0, 'hBEEF);

      for (int r = 0; r < vecs.size(); r++) begin
         Reset_N     = vecs[r].rst_n;
         i_req       = vecs[r].i_req;
         i_addr      = vecs[r].i_addr;
         d_req_read  = vecs[r].d_rd;
         d_req_write = vecs[r].d_wr;
         d_addr      = vecs[r].d_addr;
         d_wdata     = vecs[r].d_wdata;
         @(posedge Clk);
         #1;
         chk($sformatf("r%0d.mem_read", r), mem_read, vecs[r].mr);
         chk($sformatf("r%0d.mem_write", r), mem_write, vecs[r].mw);
         if (vecs[r].mr || vecs[r].mw) chk($sformatf("r%0d.mem_addr", r), mem_addr, vecs[r].ma);
         if (vecs[r].mw) chk($sformatf("r%0d.mem_wdata", r), mem_wdata, vecs[r].mwd);
         chk($sformatf("r%0d.i_ready", r), i_ready, vecs[r].ir);
         chk($sformatf("r%0d.i_rdata", r), i_rdata, vecs[r].ird);
         chk($sformatf("r%0d.d_ready", r), d_ready, vecs[r].dr);
         chk($sformatf("r%0d.d_rdata", r), d_rdata, vecs[r].drd);
      end

      // Reset mid-ACCESS: outputs cleared, no ready pulse afterwards
      drive_idle();
      i_req = 1'b1; i_addr = 16'h0023;
      @(posedge Clk);
      #1;
      chk("midrst.in_access", mem_read, 1);
      Reset_N = 1'b0;
      i_req   = 1'b0;
      @(posedge Clk);
      #1;
      chk("midrst.mem_read", mem_read, 0);
      chk("midrst.mem_addr", mem_addr, 0);
      chk("midrst.i_ready", i_ready, 0);
      chk("midrst.i_rdata", i_rdata, 0);
      chk("midrst.d_rdata", d_rdata, 0);
      Reset_N = 1'b1;
      pulses = 0;
      repeat (4) begin
         @(posedge Clk);
         #1;
         if (i_ready || d_ready || mem_read || mem_write) pulses++;
      end
      chk("midrst.no_activity", pulses, 0);

      // First contention after reset goes to D, then I; latency and results checked
      i_req = 1'b1; i_addr = 16'h0030;
      d_req_read = 1'b1; d_addr = 16'h0040;
      n = 0;
      do begin
         @(posedge Clk);
         #1;
         n++;
      end while (!d_ready && !i_ready && n < 8);
      chk("post.first_is_d", d_ready, 1);
      chk("post.d_latency", n, 3);
      chk("post.d_rdata", d_rdata, 16'h1234);
      d_req_read = 1'b0;
      n = 0;
      do begin
         @(posedge Clk);
         #1;
         n++;
      end while (!i_ready && n < 10);
      chk("post.i_ready", i_ready, 1);
      chk("post.i_gap", n, 4);
      chk("post.i_rdata", i_rdata, 16'h0A0A);
      i_req = 1'b0;
      repeat (2) @(posedge Clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
